// File: rtl/validator_dispatcher.sv
// Round-robin fan-out of the transaction stream to LANES validator workers with in-order merge.
// Optional event counters are compiled in with VALIDATOR_DISPATCH_STATS_EN.
module validator_dispatcher #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    valid_i,
  output logic                    ack_o,
  output logic [LANES*DATA_W-1:0] wrk_data_o,
  output logic [LANES-1:0]        wrk_valid_o,
  input  logic [LANES-1:0]        wrk_ready_i,
  input  logic [LANES*DATA_W-1:0] wrk_data_i,
  input  logic [LANES-1:0]        wrk_valid_i,
  output logic [LANES-1:0]        wrk_ack_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    flush_done_o
`ifdef VALIDATOR_DISPATCH_STATS_EN
  ,
  output logic [31:0]             stat_disp_o,
  output logic [31:0]             stat_ret_o,
  output logic [31:0]             stat_stall_o
`endif
);
  localparam int            PW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] LAST = PW'(LANES - 1);
  localparam logic [2:0]    MAXC = 3'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [PW-1:0]                disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
  logic [LANES-1:0][2:0]        cnt_q, cnt_d;
  logic [LANES-1:0][DATA_W-1:0] lane_in, lane_out_q;
  logic [LANES-1:0]             wrk_valid_q, lane_busy;
  logic [DATA_W-1:0]            data_q;
  logic                         valid_q, busy_q, busy_d, disp, ret, drained;

  assign lane_in     = wrk_data_i;
  assign wrk_data_o  = lane_out_q;
  assign wrk_valid_o = wrk_valid_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) lane_busy[k] = (cnt_q[k] != 3'd0);
  end
  assign drained = ~|lane_busy;

  // Results on a lane with nothing outstanding are never acknowledged.
  always_comb begin
    disp         = !rst && (state_q == RUN) && valid_i && wrk_ready_i[disp_ptr_q] &&
                   (cnt_q[disp_ptr_q] < MAXC);
    ret          = !rst && ready_i && wrk_valid_i[ret_ptr_q] && lane_busy[ret_ptr_q];
    ack_o        = disp;
    wrk_ack_o    = ret ? (LANES'(1) << ret_ptr_q) : '0;
    flush_done_o = !rst && (state_q == DRAIN) && drained && !ret;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i) state_d = DRAIN; else if (enable_i) state_d = RUN;
      RUN:     if (flush_i) state_d = DRAIN; else if (!enable_i) state_d = IDLE;
      DRAIN:   if (flush_done_o) state_d = enable_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp_ptr_d = disp_ptr_q;
    ret_ptr_d  = ret_ptr_q;
    if (disp) disp_ptr_d = (disp_ptr_q == LAST) ? '0 : disp_ptr_q + 1'b1;
    if (ret)  ret_ptr_d  = (ret_ptr_q == LAST) ? '0 : ret_ptr_q + 1'b1;
    if (flush_done_o) begin
      disp_ptr_d = '0;
      ret_ptr_d  = '0;
    end
    busy_d = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      cnt_d[k] = cnt_q[k];
      if ((disp && disp_ptr_q == PW'(k)) && !(ret && ret_ptr_q == PW'(k)))
        cnt_d[k] = cnt_q[k] + 3'd1;
      else if (!(disp && disp_ptr_q == PW'(k)) && (ret && ret_ptr_q == PW'(k)))
        cnt_d[k] = cnt_q[k] - 3'd1;
      busy_d = busy_d | (cnt_d[k] != 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      disp_ptr_q  <= '0;
      ret_ptr_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      wrk_valid_q <= '0;
      lane_out_q  <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      disp_ptr_q  <= disp_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      wrk_valid_q <= disp ? (LANES'(1) << disp_ptr_q) : '0;
      if (disp) lane_out_q[disp_ptr_q] <= data_i;
      valid_q     <= ret;
      if (ret) data_q <= lane_in[ret_ptr_q];
    end
  end

`ifdef VALIDATOR_DISPATCH_STATS_EN
  logic [31:0] sdisp_q, sret_q, sstall_q;
  assign stat_disp_o  = sdisp_q;
  assign stat_ret_o   = sret_q;
  assign stat_stall_o = sstall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sdisp_q  <= '0;
      sret_q   <= '0;
      sstall_q <= '0;
    end else begin
      if (disp) sdisp_q <= sdisp_q + 32'd1;
      if (ret)  sret_q  <= sret_q + 32'd1;
      if ((state_q == RUN) && valid_i && !disp) sstall_q <= sstall_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_validator_dispatcher.sv
// Bench for validator_dispatcher: behavioural workers, an in-order scoreboard and directed corner cases.
module tb_validator_dispatcher;
  localparam int LANES = 4, DW = 32, MO = 2;

  logic clk = 1'b0, rst, enable_i, flush_i, valid_i, ack_o, valid_o, ready_i, busy_o, flush_done_o;
  logic [DW-1:0]       data_i, data_o;
  logic [LANES*DW-1:0] wrk_data_o, wrk_data_i;
  logic [LANES-1:0]    wrk_valid_o, wrk_ready_i, wrk_valid_i, wrk_ack_o;
`ifdef VALIDATOR_DISPATCH_STATS_EN
  logic [31:0] stat_disp_o, stat_ret_o, stat_stall_o;
`endif

  always #5 clk = ~clk;

  validator_dispatcher #(.LANES(LANES), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .flush_i(flush_i), .data_i(data_i),
    .valid_i(valid_i), .ack_o(ack_o), .wrk_data_o(wrk_data_o), .wrk_valid_o(wrk_valid_o),
    .wrk_ready_i(wrk_ready_i), .wrk_data_i(wrk_data_i), .wrk_valid_i(wrk_valid_i),
    .wrk_ack_o(wrk_ack_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .flush_done_o(flush_done_o)
`ifdef VALIDATOR_DISPATCH_STATS_EN
    , .stat_disp_o(stat_disp_o), .stat_ret_o(stat_ret_o), .stat_stall_o(stat_stall_o)
`endif
  );

  typedef struct { int lat0; int latr; int nwords; int delay; } vec_t;
  vec_t vt[4];

  int checks, errors, cyc;
  int disp_idx, n_acc, n_ret, n_out, n_fd, fd_cyc, last_ret_cyc;
  bit rand_mode, last_ack, last_vo;
  logic [LANES-1:0] hold, last_wa;
  int lat[LANES];
  logic [DW-1:0] in_q[$], exp_q[$], pend_d[$];
  int pend_l[$], lane_log[$], ack_cyc[$], out_cyc[$];
  logic [DW-1:0] wq_d[LANES][$];
  int wq_t[LANES][$];

  // Worker transform: results differ from the transaction so a pass-through shows up.
  function automatic logic [DW-1:0] wres(input logic [DW-1:0] d);
    return ~d;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    valid_i = (in_q.size() != 0);
    data_i  = valid_i ? in_q[0] : '0;
    wrk_data_i = '0;
    for (int k = 0; k < LANES; k++) begin
      wrk_valid_i[k] = (wq_d[k].size() != 0) && !hold[k];
      if (wrk_valid_i[k]) wrk_valid_i[k] = (wq_t[k][0] <= cyc);
      if (wrk_valid_i[k]) wrk_data_i[k*DW +: DW] = wres(wq_d[k][0]);
    end
  endtask

  task automatic step();
    bit a, fd;
    logic [DW-1:0] ad;
    logic [LANES-1:0] wa;
    @(negedge clk);
    chk($countones(wrk_valid_o) <= 1, "issue_onehot", wrk_valid_o, 0);
    for (int k = 0; k < LANES; k++) if (wrk_valid_o[k]) begin
      chk(pend_l.size() != 0, "issue_unexpected", k, 0);
      if (pend_l.size() != 0) begin
        chk(pend_l[0] == k, "issue_lane", k, pend_l[0]);
        chk(wrk_data_o[k*DW +: DW] == pend_d[0], "issue_data", wrk_data_o[k*DW +: DW], pend_d[0]);
        void'(pend_l.pop_front());
        void'(pend_d.pop_front());
      end
      lane_log.push_back(k);
      wq_d[k].push_back(wrk_data_o[k*DW +: DW]);
      wq_t[k].push_back(cyc + lat[k]);
    end
    if (valid_o) begin
      chk(exp_q.size() != 0, "out_unexpected", data_o, 0);
      if (exp_q.size() != 0) begin
        chk(data_o == exp_q[0], "out_data", data_o, exp_q[0]);
        void'(exp_q.pop_front());
      end
      n_out++;
      out_cyc.push_back(cyc);
    end
    chk(busy_o == (n_acc != n_ret), "busy", busy_o, n_acc != n_ret);
    fd = flush_done_o;
    if (fd) begin n_fd++; fd_cyc = cyc; end
    a = ack_o; ad = data_i; wa = wrk_ack_o;
    last_ack = a; last_wa = wa; last_vo = valid_o;
    if (a) chk(valid_i, "ack_no_input", a, valid_i);
    for (int k = 0; k < LANES; k++) if (wa[k]) chk(wrk_valid_i[k], "ack_no_result", wa, wrk_valid_i);
    @(posedge clk); #1;
    if (a && in_q.size() != 0) begin
      void'(in_q.pop_front());
      exp_q.push_back(wres(ad));
      pend_d.push_back(ad);
      pend_l.push_back(disp_idx);
      disp_idx = (disp_idx + 1) % LANES;
      n_acc++;
      ack_cyc.push_back(cyc);
    end
    for (int k = 0; k < LANES; k++) if (wa[k] && wq_d[k].size() != 0) begin
      void'(wq_d[k].pop_front());
      void'(wq_t[k].pop_front());
      n_ret++;
      last_ret_cyc = cyc;
    end
    if (fd) disp_idx = 0;
    cyc++;
    if (rand_mode) begin
      ready_i     = ($urandom_range(0, 3) != 0);
      wrk_ready_i = LANES'($urandom);
      if ($urandom_range(0, 2) == 0) in_q.push_back($urandom);
      flush_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) enable_i = ~enable_i;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable_i = 0; flush_i = 0; ready_i = 1; wrk_ready_i = '1; hold = '0; rand_mode = 0;
    in_q.delete(); exp_q.delete(); pend_d.delete(); pend_l.delete();
    lane_log.delete(); ack_cyc.delete(); out_cyc.delete();
    for (int k = 0; k < LANES; k++) begin wq_d[k].delete(); wq_t[k].delete(); end
    disp_idx = 0; n_acc = 0; n_ret = 0; n_out = 0; n_fd = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_zero();
    @(negedge clk);
    chk(ack_o == 0, "rst_ack", ack_o, 0);
    chk(wrk_valid_o == 0, "rst_wrk_valid", wrk_valid_o, 0);
    chk(wrk_data_o == 0, "rst_wrk_data", wrk_data_o, 0);
    chk(wrk_ack_o == 0, "rst_wrk_ack", wrk_ack_o, 0);
    chk(data_o == 0, "rst_data", data_o, 0);
    chk(valid_o == 0, "rst_valid", valid_o, 0);
    chk(busy_o == 0, "rst_busy", busy_o, 0);
    chk(flush_done_o == 0, "rst_flush_done", flush_done_o, 0);
`ifdef VALIDATOR_DISPATCH_STATS_EN
    chk(stat_disp_o == 0 && stat_ret_o == 0 && stat_stall_o == 0, "rst_stats", stat_disp_o, 0);
`endif
    @(posedge clk); #1;
    cyc++;
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || pend_l.size() != 0 || n_acc != n_ret) && n < budget) begin
      step();
      n++;
    end
    chk(n < budget, "drain_timeout", n, budget);
  endtask

  task automatic set_lat(input int l0, input int lr);
    lat[0] = l0;
    for (int k = 1; k < LANES; k++) lat[k] = lr;
  endtask

  initial begin
    int acc0;
`ifdef VALIDATOR_DISPATCH_STATS_EN
    logic [31:0] st0;
`endif
    checks = 0; errors = 0; cyc = 0; fd_cyc = 0; last_ret_cyc = 0;
    vt[0] = '{lat0: 3,  latr: 3, nwords: 8, delay: 5};
    vt[1] = '{lat0: 20, latr: 1, nwords: 4, delay: 22};
    vt[2] = '{lat0: 1,  latr: 1, nwords: 6, delay: 3};
    vt[3] = '{lat0: 5,  latr: 2, nwords: 7, delay: 7};
    set_lat(1, 1);

    // Latency table: in-order merge, lane rotation, back-to-back acks, first-result delay.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      check_zero();
      set_lat(vt[r].lat0, vt[r].latr);
      enable_i = 1;
      for (int i = 0; i < vt[r].nwords; i++) in_q.push_back(DW'((r << 8) + i + 1));
      drive();
      run_idle(300);
      chk(n_out == vt[r].nwords, "tbl_count", n_out, vt[r].nwords);
      chk(ack_cyc.size() == vt[r].nwords, "tbl_acks", ack_cyc.size(), vt[r].nwords);
      if (ack_cyc.size() == vt[r].nwords && out_cyc.size() != 0) begin
        chk(ack_cyc[vt[r].nwords-1] - ack_cyc[0] == vt[r].nwords - 1, "tbl_ack_consec",
            ack_cyc[vt[r].nwords-1] - ack_cyc[0], vt[r].nwords - 1);
        chk(out_cyc[0] - ack_cyc[0] == vt[r].delay, "tbl_delay", out_cyc[0] - ack_cyc[0], vt[r].delay);
      end
      for (int i = 0; i < lane_log.size(); i++) chk(lane_log[i] == i % LANES, "tbl_lane", lane_log[i], i % LANES);
    end

    // Lane 2 never answers: dispatch stalls once lane 2 holds MAX_OUT.
    do_reset(); check_zero();
    set_lat(2, 2); hold[2] = 1'b1; enable_i = 1;
    for (int i = 0; i < 12; i++) in_q.push_back(DW'(32'h100 + i));
    drive();
    repeat (30) step();
    chk(n_acc == 10, "stall_acks", n_acc, 10);
    chk(n_out == 2, "stall_outs", n_out, 2);
`ifdef VALIDATOR_DISPATCH_STATS_EN
    st0 = stat_stall_o;
    chk(stat_disp_o == 10, "stat_disp", stat_disp_o, 10);
    chk(stat_ret_o == 2, "stat_ret", stat_ret_o, 2);
`endif
    repeat (5) begin
      step();
      chk(!last_ack, "stall_no_ack", last_ack, 0);
      chk(busy_o, "stall_busy", busy_o, 1);
    end
`ifdef VALIDATOR_DISPATCH_STATS_EN
    chk(stat_stall_o - st0 == 5, "stat_stall", stat_stall_o - st0, 5);
`endif
    hold = '0; drive();
    run_idle(200);
    chk(n_out == 12, "stall_release", n_out, 12);

    // Output FIFO almost full: nothing retires, then results drain back to back.
    do_reset(); check_zero();
    set_lat(1, 1); ready_i = 0; enable_i = 1;
    for (int i = 0; i < 4; i++) in_q.push_back(DW'(32'h200 + i));
    drive();
    repeat (14) begin
      step();
      chk(last_wa == 0 && !last_vo, "rdy_low_hold", {last_wa, last_vo}, 0);
    end
    ready_i = 1; out_cyc.delete();
    run_idle(100);
    chk(out_cyc.size() == 4, "rdy_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4) chk(out_cyc[3] - out_cyc[0] == 3, "rdy_consec", out_cyc[3] - out_cyc[0], 3);

    // Flush with five in flight; new input must wait until the drain completes.
    do_reset(); check_zero();
    set_lat(2, 2); hold = '1; enable_i = 1;
    for (int i = 0; i < 5; i++) in_q.push_back(DW'(32'h300 + i));
    drive();
    repeat (10) step();
    chk(n_acc == 5, "fl_inflight", n_acc, 5);
    flush_i = 1;
    step();
    flush_i = 0;
    for (int i = 0; i < 3; i++) in_q.push_back(DW'(32'h400 + i));
    hold = '0; drive();
    acc0 = n_acc;
    for (int n = 0; n < 100 && n_fd == 0; n++) step();
    chk(n_fd == 1, "fl_done_seen", n_fd, 1);
    chk(n_acc == acc0, "fl_no_ack", n_acc, acc0);
    chk(fd_cyc == last_ret_cyc + 1, "fl_done_cycle", fd_cyc, last_ret_cyc + 1);
    run_idle(200);
    chk(n_fd == 1, "fl_single_pulse", n_fd, 1);
    chk(lane_log.size() == 8, "fl_issues", lane_log.size(), 8);
    if (lane_log.size() == 8) chk(lane_log[5] == 0, "fl_lane0", lane_log[5], 0);

    // Reset with three in flight.
    do_reset(); check_zero();
    set_lat(2, 2); hold = '1; enable_i = 1;
    for (int i = 0; i < 3; i++) in_q.push_back(DW'(32'h500 + i));
    drive();
    repeat (8) step();
    chk(n_acc == 3 && busy_o, "mid_inflight", n_acc, 3);
    do_reset(); check_zero();
    in_q.push_back(32'h600); drive();
    repeat (4) step();
    chk(n_acc == 0, "mid_idle_no_ack", n_acc, 0);

    // Random traffic against the scoreboard.
    do_reset(); check_zero();
    for (int k = 0; k < LANES; k++) lat[k] = $urandom_range(1, 6);
    enable_i = 1; rand_mode = 1;
    repeat (1500) step();
    rand_mode = 0; enable_i = 1; flush_i = 0; ready_i = 1; wrk_ready_i = '1; drive();
    run_idle(3000);
    chk(n_out == n_acc, "rnd_all_out", n_out, n_acc);
`ifdef VALIDATOR_DISPATCH_STATS_EN
    chk(stat_disp_o == n_acc && stat_ret_o == n_ret, "rnd_stats", stat_disp_o, n_acc);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
